// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//
// Multiplexed driver for a block of 7-segment LED digits. A clock-enable
// prescaler creates 16 PWM phases per digit slot, and the scan steps through
// the digits in turn. All inputs are captured into shadow registers once per
// frame so the displayed value never tears.
//
// Optional feature macro: SEVEN_SEG_BLINK_EN. When defined, a 6-bit frame
// counter gives per-digit blinking (32 frames on, 32 frames dark). When not
// defined, blink_enable is accepted but ignored.
//
// Ports:
//   clk                    - single clock, rising edge
//   reset_n                - asynchronous active-low reset
//   data                   - DIGITS hex nibbles, nibble i drives digit i
//   digit_enable           - 1 = digit i may light
//   decimal_point_enable   - 1 = dp lit on digit i
//   blink_enable           - 1 = digit i blinks (blink build only)
//   lz_blank               - 1 = leading-zero blanking on
//   brightness             - lit phases per 16-phase slot (0 = dark)
//   display_led_segments   - {a,b,c,d,e,f,g,dp}, polarity per SEG_ACTIVE_LOW
//   display_segment_enable - digit selects, polarity per DIG_ACTIVE_LOW
//   frame_start            - one-cycle pulse at each snapshot load
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | reset just released; take the first snapshot, hold counters
// ST_SCAN | normal scanning; snapshot at every frame wrap

module seven_segment_scanner #(
    parameter int CLK_RATE_HZ     = 390625,
    parameter int DIGITS          = 6,
    parameter int REFRESH_RATE_HZ = 80,
    parameter int CLK_DIVIDE      = 1,
    parameter int SEG_ACTIVE_LOW  = 0,
    parameter int DIG_ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DIGITS*4-1:0]   data,
    input  logic [DIGITS-1:0]     digit_enable,
    input  logic [DIGITS-1:0]     decimal_point_enable,
    input  logic [DIGITS-1:0]     blink_enable,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [7:0]            display_led_segments,
    output logic [DIGITS-1:0]     display_segment_enable,
    output logic                  frame_start
);

    localparam int RAW_PHASE    = CLK_RATE_HZ / (REFRESH_RATE_HZ * DIGITS * 16);
    localparam int PHASE_CYCLES = (CLK_DIVIDE == 0) ? 1 : ((RAW_PHASE < 1) ? 1 : RAW_PHASE);
    localparam int PW           = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int IW           = $clog2(DIGITS);

    localparam logic [PW-1:0]     PRESC_LAST   = PW'(PHASE_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_LAST     = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_INACTIVE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_INACTIVE = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    typedef enum logic {ST_LOAD, ST_SCAN} state_t;

    state_t state, state_nxt;

    logic [PW-1:0] presc;
    logic [3:0]    phase;
    logic [IW-1:0] idx;
    logic          tick;
    logic          advance;
    logic          snap;

    logic [DIGITS*4-1:0] sh_data;
    logic [DIGITS-1:0]   sh_en;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_lz;
    logic [3:0]          sh_bright;

    logic                blink_dark;
    logic [DIGITS-1:0]   lz_dark;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                lit;
    logic [7:0]          seg_nxt;
    logic [DIGITS-1:0]   sel_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    assign tick = (presc == PRESC_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_LOAD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_LOAD: begin
                // Counters stay at 0/0 so the first frame gets a full slot.
                snap      = 1'b1;
                state_nxt = ST_SCAN;
            end
            default: begin
                advance = 1'b1;
                snap    = tick && (phase == 4'd15) && (idx == IDX_LAST);
            end
        endcase
    end

    // ---------------- scan counters ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= 4'd0;
            idx   <= '0;
        end else if (advance) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                phase <= phase + 4'd1;
                if (phase == 4'd15)
                    idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // ---------------- per-frame snapshot ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_data     <= '0;
            sh_en       <= '0;
            sh_dp       <= '0;
            sh_lz       <= 1'b0;
            sh_bright   <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap;
            if (snap) begin
                sh_data   <= data;
                sh_en     <= digit_enable;
                sh_dp     <= decimal_point_enable;
                sh_lz     <= lz_blank;
                sh_bright <= brightness;
            end
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    logic [5:0]        frame_cnt;
    logic [DIGITS-1:0] sh_blink;
    logic              sh_blink_off;

    // The blink phase is latched with the snapshot using the count before
    // increment, so frames 0..31 after reset are on and 32..63 are dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt    <= 6'd0;
            sh_blink     <= '0;
            sh_blink_off <= 1'b0;
        end else if (snap) begin
            frame_cnt    <= frame_cnt + 6'd1;
            sh_blink     <= blink_enable;
            sh_blink_off <= frame_cnt[5];
        end
    end

    assign blink_dark = sh_blink_off && sh_blink[idx];
`else
    logic unused_blink;
    assign unused_blink = ^blink_enable;
    assign blink_dark   = 1'b0;
`endif

    // Leading-zero blanking: walk from the top digit down while nibbles are
    // zero and no dp is set; digit 0 is never blanked.
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (sh_data[i*4 +: 4] == 4'h0) && !sh_dp[i];
            if (i != 0) lz_dark[i] = sh_lz && zero_run;
        end
    end

    always_comb begin
        cur_nib = sh_data[int'(idx)*4 +: 4];
        // Phase 15 is forced dark to give dead time between digits.
        lit     = (phase < sh_bright) && (phase != 4'd15) && sh_en[idx]
                  && !lz_dark[idx] && !blink_dark;
        seg_nxt = lit ? {hex7(cur_nib), sh_dp[idx]} : 8'h00;
        sel_nxt = '0;
        if (lit) sel_nxt[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            display_led_segments   <= SEG_INACTIVE;
            display_segment_enable <= DIG_INACTIVE;
        end else begin
            display_led_segments   <= seg_nxt ^ SEG_INACTIVE;
            display_segment_enable <= sel_nxt ^ DIG_INACTIVE;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//
// Directed bench for seven_segment_scanner with DIGITS=4, CLK_DIVIDE=0
// (one PWM phase per clock, 64-cycle frames). Expected segment bytes are
// hand-computed from the hex table. Honours SEVEN_SEG_BLINK_EN for the
// blink frames.

module tb_seven_segment_scanner;

    logic        clk;
    logic        reset_n;
    logic [15:0] data;
    logic [3:0]  digit_enable;
    logic [3:0]  decimal_point_enable;
    logic [3:0]  blink_enable;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [7:0]  display_led_segments;
    logic [3:0]  display_segment_enable;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    seven_segment_scanner #(
        .DIGITS     (4),
        .CLK_DIVIDE (0)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .data                   (data),
        .digit_enable           (digit_enable),
        .decimal_point_enable   (decimal_point_enable),
        .blink_enable           (blink_enable),
        .lz_blank               (lz_blank),
        .brightness             (brightness),
        .display_led_segments   (display_led_segments),
        .display_segment_enable (display_segment_enable),
        .frame_start            (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one 64-cycle frame. exp byte d is digit d's segment byte, or 0
    // if that digit must stay dark all frame.
    task automatic check_frame(input logic [31:0] exp, input int bright);
        int         ph;
        int         d;
        logic [7:0] eb;
        logic       lit;
        logic [3:0] esel;
        logic [7:0] eseg;
        for (int j = 0; j < 64; j++) begin
            @(posedge clk);
            @(negedge clk);
            ph   = j % 16;
            d    = j / 16;
            eb   = exp[d*8 +: 8];
            lit  = (eb != 8'h00) && (ph < bright) && (ph != 15);
            esel = lit ? 4'(1 << d) : 4'h0;
            eseg = lit ? eb : 8'h00;
            chk("sel", 32'(display_segment_enable), 32'(esel));
            chk("seg", 32'(display_led_segments), 32'(eseg));
            chk("frame_start", 32'(frame_start), (j == 63) ? 32'd1 : 32'd0);
        end
    endtask

    localparam logic [31:0] E1234 = {8'h60, 8'hDA, 8'hF2, 8'h66};
    localparam logic [31:0] ELZ   = {8'h00, 8'h00, 8'h00, 8'hB6};
    localparam logic [31:0] ELZDP = {8'h00, 8'h00, 8'hFD, 8'hB6};
    localparam logic [31:0] EABCD = {8'h00, 8'h3E, 8'h00, 8'h7A};
    localparam logic [31:0] EBLNK = {8'h60, 8'hDA, 8'hF2, 8'h00};

    initial begin
        reset_n              = 1'b0;
        data                 = 16'h1234;
        digit_enable         = 4'hF;
        decimal_point_enable = 4'h0;
        blink_enable         = 4'h0;
        lz_blank             = 1'b0;
        brightness           = 4'd15;

        repeat (3) @(negedge clk);
        chk("reset seg", 32'(display_led_segments), 32'h00);
        chk("reset sel", 32'(display_segment_enable), 32'h0);
        chk("reset frame_start", 32'(frame_start), 32'd0);

        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first edge frame_start", 32'(frame_start), 32'd1);
        chk("first edge sel", 32'(display_segment_enable), 32'h0);

        brightness = 4'd4;
        check_frame(E1234, 15);

        brightness = 4'd0;
        check_frame(E1234, 4);

        data       = 16'h0005;
        lz_blank   = 1'b1;
        brightness = 4'd15;
        check_frame(E1234, 0);

        decimal_point_enable = 4'b0010;
        check_frame(ELZ, 15);

        data                 = 16'hABCD;
        lz_blank             = 1'b0;
        decimal_point_enable = 4'h0;
        digit_enable         = 4'b0101;
        check_frame(ELZDP, 15);

        data         = 16'h1234;
        digit_enable = 4'hF;
        blink_enable = 4'b0001;
        check_frame(EABCD, 15);

        // Mid-frame reset while digit 0 is lit.
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-reset sel", 32'(display_segment_enable), 32'h1);
        chk("pre-reset seg", 32'(display_led_segments), 32'h66);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset seg", 32'(display_led_segments), 32'h00);
        chk("async reset sel", 32'(display_segment_enable), 32'h0);
        chk("async reset frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart frame_start", 32'(frame_start), 32'd1);
        chk("restart sel", 32'(display_segment_enable), 32'h0);

        // Frames 0..31 after reset: blinking digit 0 is lit.
        for (int f = 0; f < 32; f++) check_frame(E1234, 15);
`ifdef SEVEN_SEG_BLINK_EN
        check_frame(EBLNK, 15);
        check_frame(EBLNK, 15);
`else
        check_frame(E1234, 15);
        check_frame(E1234, 15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
